// File: rtl/cim_pkg.sv
// Shared types and sizing helpers for the CIM layer pipeline.
// Used by the pool-to-fc flatten stage.
package cim_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SERIAL,
        WAIT_FC
    } state_t;

    function automatic int pool_pixels(input int w, input int k);
        return (w / k) * (w / k);
    endfunction

    function automatic int addr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pool_fc_flatten.sv
// Serialises pool output vectors into the fc input buffer in CHW order
// and kicks the fc layer once a full frame is stored.
module pool_fc_flatten
    import cim_pkg::*;
#(
    parameter int datatype_size  = 4,
    parameter int input_channels = 5,
    parameter int img_width      = 24,
    parameter int kernel_dim     = 2,
    localparam int P  = pool_pixels(img_width, kernel_dim),
    localparam int N  = input_channels * P,
    localparam int AW = addr_width(N),
    localparam int PW = addr_width(P),
    localparam int CW = addr_width(input_channels)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_valid,
    input  logic [datatype_size-1:0] i_data [input_channels],
    output logic                     o_busy,
    input  logic                     i_fc_busy,
    output logic                     o_ibuf_we,
    output logic [datatype_size-1:0] o_ibuf_wr_data,
    output logic [AW-1:0]            o_ibuf_addr,
    output logic                     o_start
);

    if (img_width % kernel_dim != 0) begin : g_bad_kernel
        $error("img_width must be a multiple of kernel_dim");
    end

    state_t                   state;
    logic [datatype_size-1:0] hold [input_channels];
    logic [CW-1:0]            ch_cnt;
    logic [PW-1:0]            pix_cnt;
    logic [AW-1:0]            base;
    logic                     last_ch;
    logic                     last_pix;

    assign o_busy   = (state != IDLE) | i_fc_busy;
    assign last_ch  = (ch_cnt == CW'(input_channels - 1));
    assign last_pix = (pix_cnt == PW'(P - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            pix_cnt        <= '0;
            ch_cnt         <= '0;
            base           <= '0;
            o_ibuf_we      <= 1'b0;
            o_ibuf_wr_data <= '0;
            o_ibuf_addr    <= '0;
            o_start        <= 1'b0;
            for (int i = 0; i < input_channels; i++) begin
                hold[i] <= '0;
            end
        end else begin
            o_ibuf_we <= 1'b0;
            o_start   <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (i_valid && !o_busy) begin
                        hold   <= i_data;
                        ch_cnt <= '0;
                        base   <= AW'(pix_cnt);
                        state  <= SERIAL;
                    end
                end
                SERIAL: begin
                    // base walks pix_cnt, pix_cnt+P, ... so no multiplier is needed
                    o_ibuf_we      <= 1'b1;
                    o_ibuf_wr_data <= hold[ch_cnt];
                    o_ibuf_addr    <= base;
                    base           <= base + AW'(P);
                    ch_cnt         <= ch_cnt + 1'b1;
                    if (last_ch) begin
                        ch_cnt <= '0;
                        if (last_pix) begin
                            pix_cnt <= '0;
                            state   <= WAIT_FC;
                        end else begin
                            pix_cnt <= pix_cnt + 1'b1;
                            state   <= IDLE;
                        end
                    end
                end
                WAIT_FC: begin
                    if (!i_fc_busy) begin
                        o_start <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
